// File: rtl/uart_pkg.sv
// Shared UART package: receiver/transmitter state encoding, data width and half-bit helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  localparam int DATA_BITS = 8;

  // Odd bit periods round the half-bit down.
  function automatic int half_bit(input int bit_cycles);
    return bit_cycles / 2;
  endfunction

endpackage

// File: rtl/uart_rx_framer_if.sv
// Received-byte stream: valid/ready handshake carrying one byte per transfer.
interface uart_rx_framer_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_framer.sv
// Mid-bit sampled 8N1 UART receiver: glitch reject, frame_err/overrun pulses, one-entry output register.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err pulse output.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int PRESCALER = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rx,
  uart_rx_framer_if.master rx_out,
  output logic             frame_err,
`ifdef UART_RX_PARITY_EN
  output logic             parity_err,
`endif
  output logic             overrun
);

  localparam int CNT_W = $clog2(PRESCALER);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(PRESCALER - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(half_bit(PRESCALER) - 1);

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 done_q, done_d;
  logic                 frame_err_q, frame_err_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    done_d      = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif

    if (state_q != IDLE && state_q != BREAK) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (!rx) begin
          cnt_d   = HALF_LOAD;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (!rx) begin
            cnt_d     = BIT_LOAD;
            bit_idx_d = 3'd0;
            state_d   = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shreg_d = {rx, shreg_q[DATA_BITS-1:1]};
          cnt_d   = BIT_LOAD;
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == '0) begin
          par_d   = rx;
          cnt_d   = BIT_LOAD;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        // Leave at mid-stop so a start bit right after the stop bit is caught.
        if (cnt_q == '0) begin
          if (rx) begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (^{shreg_q, par_q}) begin
              parity_err_d = 1'b1;
            end else begin
              done_d = 1'b1;
            end
`else
            done_d = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register: a completed byte may replace a byte being accepted in the same cycle.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    if (done_q) begin
      if (!rx_valid_q || rx_out.rx_ready) begin
        rx_data_d  = shreg_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_out.rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shreg_q     <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_out.rx_data  = rx_data_q;
  assign rx_out.rx_valid = rx_valid_q;
  assign frame_err       = frame_err_q;
  assign overrun         = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err      = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer: directed scenarios plus randomized frames against a byte-queue model.
module tb_uart_rx_framer;

  localparam int P = 24;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = P*10 + P/2 + 1;
`else
  localparam int LAT = P*9 + P/2 + 1;
`endif

  logic clk;
  logic reset_n;
  logic rx;
  logic frame_err;
  logic overrun;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
`endif

  uart_rx_framer_if bus();

  uart_rx_framer #(.PRESCALER(P)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .rx_out    (bus.master),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Observation side: sampled on the falling edge, away from the active edge.
  int         cyc = 0;
  int         fe_cnt, ov_cnt, vld_cycles, vld_rise_cyc;
  logic       vld_prev = 1'b0;
  logic [7:0] got[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (bus.rx_valid === 1'b1) vld_cycles++;
    if (bus.rx_valid === 1'b1 && vld_prev !== 1'b1) vld_rise_cyc = cyc;
    vld_prev = bus.rx_valid;
    if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) got.push_back(bus.rx_data);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_obs();
    fe_cnt = 0; ov_cnt = 0; vld_cycles = 0; vld_rise_cyc = -1;
    got.delete();
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (P) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int idle_after);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^b);
`endif
    drive_bit(stop_ok);
    rx = 1'b1;
    repeat (idle_after) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; rx = 1'b1; bus.rx_ready = 1'b0;
    repeat (3) tick();
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.rx_valid); end
    total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", bus.rx_data); end
    total++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL reset_pulses got fe=%b ov=%b want 0 0", frame_err, overrun); end
    reset_n = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_basic();
    int st;
    bus.rx_ready = 1'b1;
    clear_obs();
    st = cyc + 1;
    send_frame(8'hA5, 1'b1, 30);
    total++; if (vld_rise_cyc - st !== LAT || LAT != 229 && P == 24 && LAT == P*9 + P/2 + 1)
      begin bad++; $display("FAIL basic_latency got=%0d want=%0d", vld_rise_cyc - st, LAT); end
    total++; if (got.size() != 1 || got[0] !== 8'hA5) begin bad++; $display("FAIL basic_data got_n=%0d first=%h want 1 A5", got.size(), got.size() ? got[0] : 8'hxx); end
    total++; if (vld_cycles != 1) begin bad++; $display("FAIL basic_valid_width got=%0d want=1", vld_cycles); end
    total++; if (fe_cnt != 0 || ov_cnt != 0) begin bad++; $display("FAIL basic_pulses got fe=%0d ov=%0d want 0 0", fe_cnt, ov_cnt); end
  endtask

  task automatic test_glitch();
    int st;
    bus.rx_ready = 1'b1;
    clear_obs();
    rx = 1'b0;
    repeat (8) tick();
    rx = 1'b1;
    repeat (40) tick();
    total++; if (vld_cycles != 0 || fe_cnt != 0) begin bad++; $display("FAIL glitch_reject got vld=%0d fe=%0d want 0 0", vld_cycles, fe_cnt); end
    st = cyc + 1;
    send_frame(8'h5A, 1'b1, 30);
    total++; if (got.size() != 1 || got[0] !== 8'h5A || vld_rise_cyc - st !== LAT)
      begin bad++; $display("FAIL glitch_then_frame got_n=%0d lat=%0d want 1 byte 5A lat %0d", got.size(), vld_rise_cyc - st, LAT); end
  endtask

  task automatic test_frame_err();
    bus.rx_ready = 1'b1;
    clear_obs();
    send_frame(8'h3C, 1'b0, 0);
    rx = 1'b0;
    repeat (100) tick();
    rx = 1'b1;
    repeat (10) tick();
    total++; if (fe_cnt != 1) begin bad++; $display("FAIL frame_err_count got=%0d want=1", fe_cnt); end
    total++; if (vld_cycles != 0) begin bad++; $display("FAIL frame_err_no_valid got=%0d want=0", vld_cycles); end
    send_frame(8'h55, 1'b1, 30);
    total++; if (got.size() != 1 || got[0] !== 8'h55) begin bad++; $display("FAIL frame_err_recover got_n=%0d want 1 byte 55", got.size()); end
  endtask

  task automatic test_overrun();
    bus.rx_ready = 1'b0;
    clear_obs();
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 30);
    total++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h11) begin bad++; $display("FAIL overrun_hold got v=%b d=%h want 1 11", bus.rx_valid, bus.rx_data); end
    total++; if (ov_cnt != 1) begin bad++; $display("FAIL overrun_count got=%0d want=1", ov_cnt); end
    bus.rx_ready = 1'b1;
    repeat (5) tick();
    total++; if (got.size() != 1 || got[0] !== 8'h11 || bus.rx_valid !== 1'b0)
      begin bad++; $display("FAIL overrun_drain got_n=%0d v=%b want 1 byte 11 v=0", got.size(), bus.rx_valid); end
  endtask

  task automatic test_back_to_back();
    int c;
    bus.rx_ready = 1'b0;
    clear_obs();
    send_frame(8'h11, 1'b1, 0);
    c = cyc;
    fork
      send_frame(8'h22, 1'b1, 30);
      begin
        // The 0x22 completion cycle falls between its start edge +228 and +229.
        repeat (229) tick();
        bus.rx_ready = 1'b1;
        tick();
        bus.rx_ready = 1'b0;
        total++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h22)
          begin bad++; $display("FAIL b2b_swap got v=%b d=%h want 1 22 (t=%0d)", bus.rx_valid, bus.rx_data, cyc - c); end
      end
    join
    total++; if (ov_cnt != 0) begin bad++; $display("FAIL b2b_no_overrun got=%0d want=0", ov_cnt); end
    bus.rx_ready = 1'b1;
    repeat (3) tick();
    total++; if (got.size() != 2 || got[0] !== 8'h11 || got[1] !== 8'h22)
      begin bad++; $display("FAIL b2b_order got_n=%0d want 11 then 22", got.size()); end
  endtask

  task automatic test_reset_mid_frame();
    bus.rx_ready = 1'b0;
    clear_obs();
    send_frame(8'h77, 1'b1, 10);
    fork
      send_frame(8'hFE, 1'b1, 40);
      begin
        repeat (100) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        total++; if (bus.rx_valid !== 1'b0 || bus.rx_data !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0)
          begin bad++; $display("FAIL midreset_outputs got v=%b d=%h fe=%b ov=%b want 0 00 0 0", bus.rx_valid, bus.rx_data, frame_err, overrun); end
        bus.rx_ready = 1'b1;
        vld_cycles = 0;
      end
    join
    total++; if (vld_cycles != 0 || got.size() != 0 || fe_cnt != 0)
      begin bad++; $display("FAIL midreset_tail got vld=%0d n=%0d fe=%0d want 0 0 0", vld_cycles, got.size(), fe_cnt); end
    send_frame(8'hF0, 1'b1, 30);
    total++; if (got.size() != 1 || got[0] !== 8'hF0) begin bad++; $display("FAIL midreset_next got_n=%0d want 1 byte F0", got.size()); end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int         exp_fe = 0;
    logic [7:0] b;
    bit         ok;
    bus.rx_ready = 1'b1;
    clear_obs();
    for (int i = 0; i < 16; i++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 4) != 0);
      if (ok) exp_q.push_back(b);
      else exp_fe++;
      send_frame(b, ok, ok ? $urandom_range(0, 20) : $urandom_range(2, 20));
    end
    repeat (40) tick();
    total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", got.size(), exp_q.size()); end
    total++; if (fe_cnt != exp_fe) begin bad++; $display("FAIL rand_frame_err got=%0d want=%0d", fe_cnt, exp_fe); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      total++; if (got[i] !== exp_q[i]) begin bad++; $display("FAIL rand_byte[%0d] got=%h want=%h", i, got[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
